// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU, DMA and memory-side signals of the shared memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0]      cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [WIDTH-1:0]      cpu_rdata;

  logic                  dma_req;
  logic                  dma_we;
  logic                  dma_lock;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [WIDTH-1:0]      dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [WIDTH-1:0]      dma_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [WIDTH-1:0]      mem_rdata;

  logic [1:0]            owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU (default priority) and DMA (fairness slot, optional lock).
// Grants are same-cycle, read data returns one cycle later; a denied requester holds its request.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ARB = 2'b00, LOCK = 2'b01, FAIR = 2'b10} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [1:0]            rd_tag_q, rd_tag_d;
  logic                  cpu_gnt, dma_gnt;
  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [WIDTH-1:0]      wdata_mux;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    state_d = state_q;
    if (rst) begin
      case (state_q)
        ARB: begin
          cpu_gnt = bus.cpu_req;
          dma_gnt = bus.dma_req & ~bus.cpu_req;
          if (dma_gnt && bus.dma_lock)
            state_d = LOCK;
          else if (bus.dma_req && !dma_gnt && wait_cnt_q == WAIT_LAST)
            state_d = FAIR;
        end
        FAIR: begin
          dma_gnt = bus.dma_req;
          cpu_gnt = bus.cpu_req & ~bus.dma_req;
          if (dma_gnt && bus.dma_lock)
            state_d = LOCK;
          else
            state_d = ARB;
        end
        LOCK: begin
          // The CPU stays locked out even in the cycle the DMA releases the port.
          dma_gnt = bus.dma_req;
          if (!bus.dma_req || !bus.dma_lock)
            state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_gnt || !bus.dma_req)
      wait_cnt_d = 8'd0;
    else if (wait_cnt_q < WAIT_LAST)
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (cpu_gnt) begin
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
    end else if (dma_gnt) begin
      addr_mux  = bus.dma_addr;
      wdata_mux = bus.dma_wdata;
    end
  end

  assign mem_we   = (cpu_gnt & bus.cpu_we) | (dma_gnt & bus.dma_we);
  assign mem_re   = (cpu_gnt & ~bus.cpu_we) | (dma_gnt & ~bus.dma_we);
  assign rd_tag_d = {mem_re, dma_gnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      wait_cnt_q <= 8'd0;
      rd_tag_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.mem_we     = mem_we;
  assign bus.mem_re     = mem_re;
  assign bus.cpu_rvalid = rst & (rd_tag_q == 2'b10);
  assign bus.dma_rvalid = rst & (rd_tag_q == 2'b11);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.owner      = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants, reads and owner states;
// a negedge monitor pops and compares them against the port and a simple word memory.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; bit dma; bit we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { int cyc; bit dma; logic [31:0] data; } rd_t;
  typedef struct { int cyc; logic [1:0] owner; } own_t;

  gnt_t gq[$];
  rd_t  rq[$];
  own_t oq[$];
  gnt_t g;
  rd_t  r;
  own_t o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory behind the port; contents are set up on the first edge.
  logic [31:0] mem [0:255];
  logic        pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A5A0000 | 32'(i);
      mem[8'h04]    <= 32'hDEADBEEF;
      mem[8'h08]    <= 32'h11112222;
      mem[8'h09]    <= 32'h33334444;
      bus.mem_rdata <= 32'h0;
      pre_done      <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  logic        p_cpu_pend = 1'b0;
  logic [64:0] p_cpu      = '0;
  logic        p_dma_pend = 1'b0;
  logic [65:0] p_dma      = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_strobes", 64'({bus.cpu_gnt, bus.dma_gnt, bus.mem_we, bus.mem_re,
                                bus.cpu_rvalid, bus.dma_rvalid}), 64'(0));
      chk("reset_owner", 64'(bus.owner), 64'(0));
      p_cpu_pend = 1'b0;
      p_dma_pend = 1'b0;
    end else begin
      if (p_cpu_pend && bus.cpu_req && {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} != p_cpu) begin
        n_err++;
        $display("FAIL cpu_protocol at cycle %0d: fields changed before grant", cyc);
      end
      if (p_dma_pend && bus.dma_req &&
          {bus.dma_we, bus.dma_lock, bus.dma_addr, bus.dma_wdata} != p_dma) begin
        n_err++;
        $display("FAIL dma_protocol at cycle %0d: fields changed before grant", cyc);
      end

      chk("single_grant", 64'(bus.cpu_gnt & bus.dma_gnt), 64'(0));
      if (bus.cpu_gnt || bus.dma_gnt) begin
        if (gq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_grant at cycle %0d: dma_gnt=%0b cpu_gnt=%0b, none expected",
                   cyc, bus.dma_gnt, bus.cpu_gnt);
        end else begin
          g = gq.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
          chk("gnt_is_dma", 64'(bus.dma_gnt), 64'(g.dma));
          chk("gnt_we_re", 64'({bus.mem_we, bus.mem_re}), 64'({g.we, !g.we}));
          chk("gnt_addr", 64'(bus.mem_addr), 64'(g.addr));
          chk("gnt_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
        end
      end else begin
        chk("idle_port", 64'({bus.mem_we, bus.mem_re, |bus.mem_addr, |bus.mem_wdata}), 64'(0));
      end

      chk("rvalid_exclusive", 64'(bus.cpu_rvalid & bus.dma_rvalid), 64'(0));
      if (bus.cpu_rvalid || bus.dma_rvalid) begin
        if (rq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rvalid at cycle %0d: cpu=%0b dma=%0b, none expected",
                   cyc, bus.cpu_rvalid, bus.dma_rvalid);
        end else begin
          r = rq.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(r.cyc));
          chk("rd_is_dma", 64'(bus.dma_rvalid), 64'(r.dma));
          chk("rd_data", 64'(bus.dma_rvalid ? bus.dma_rdata : bus.cpu_rdata), 64'(r.data));
        end
      end

      while (oq.size() > 0 && oq[0].cyc <= cyc) begin
        o = oq.pop_front();
        chk("owner", 64'({32'(cyc), 30'b0, bus.owner}), 64'({32'(o.cyc), 30'b0, o.owner}));
      end

      p_cpu_pend = bus.cpu_req & ~bus.cpu_gnt;
      p_cpu      = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
      p_dma_pend = bus.dma_req & ~bus.dma_gnt;
      p_dma      = {bus.dma_we, bus.dma_lock, bus.dma_addr, bus.dma_wdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drive_dma(input bit req, input bit we, input bit lock,
                           input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_lock = lock; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic exp_gnt(input int c, input bit dma, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    gnt_t e;
    e.cyc = c; e.dma = dma; e.we = we; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic exp_rd(input int c, input bit dma, input logic [31:0] d);
    rd_t e;
    e.cyc = c; e.dma = dma; e.data = d;
    rq.push_back(e);
  endtask

  task automatic exp_own(input int c, input logic [1:0] ow);
    own_t e;
    e.cyc = c; e.owner = ow;
    oq.push_back(e);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    drive_cpu(0, 0, 32'h0, 32'h0);
    drive_dma(0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    tick(); tick();
    // A request while reset is held must not be granted.
    drive_cpu(1, 0, 32'h10, 32'h0);
    tick();
    drive_cpu(0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    exp_own(cyc, 2'b00);
    tick();

    // CPU-only read.
    drive_cpu(1, 0, 32'h10, 32'h0);
    exp_gnt(cyc, 0, 0, 32'h10, 32'h0);
    exp_rd(cyc + 1, 0, 32'hDEADBEEF);
    tick();
    drive_cpu(0, 0, 32'h0, 32'h0);
    tick();

    // Back-to-back CPU writes, then back-to-back readback.
    drive_cpu(1, 1, 32'h30, 32'hCAFE0001); exp_gnt(cyc, 0, 1, 32'h30, 32'hCAFE0001); tick();
    drive_cpu(1, 1, 32'h34, 32'hCAFE0002); exp_gnt(cyc, 0, 1, 32'h34, 32'hCAFE0002); tick();
    drive_cpu(1, 0, 32'h30, 32'h0); exp_gnt(cyc, 0, 0, 32'h30, 32'h0);
    exp_rd(cyc + 1, 0, 32'hCAFE0001); tick();
    drive_cpu(1, 0, 32'h34, 32'h0); exp_gnt(cyc, 0, 0, 32'h34, 32'h0);
    exp_rd(cyc + 1, 0, 32'hCAFE0002); tick();
    drive_cpu(0, 0, 32'h0, 32'h0);
    tick();

    // Contention: DMA wins only at offsets 8 and 17; offsets 7/8 also cover interleaved reads.
    t0 = cyc;
    drive_cpu(1, 0, 32'h20, 32'h77);
    drive_dma(1, 0, 0, 32'h24, 32'h88);
    for (int k = 0; k < 18; k++) begin
      if (k == 8 || k == 17) begin
        exp_gnt(t0 + k, 1, 0, 32'h24, 32'h88);
        exp_rd(t0 + k + 1, 1, 32'h33334444);
        exp_own(t0 + k, 2'b10);
      end else begin
        exp_gnt(t0 + k, 0, 0, 32'h20, 32'h77);
        exp_rd(t0 + k + 1, 0, 32'h11112222);
        exp_own(t0 + k, 2'b00);
      end
      tick();
    end
    drive_cpu(0, 0, 32'h0, 32'h0);
    drive_dma(0, 0, 0, 32'h0, 32'h0);
    exp_own(cyc, 2'b00);
    tick();

    // Locked DMA write burst while the CPU keeps requesting.
    t0 = cyc;
    drive_cpu(1, 0, 32'h10, 32'h0);
    drive_dma(1, 1, 1, 32'h100, 32'hB0000000);
    for (int k = 0; k < 8; k++) begin
      exp_gnt(t0 + k, 0, 0, 32'h10, 32'h0);
      exp_rd(t0 + k + 1, 0, 32'hDEADBEEF);
      tick();
    end
    exp_gnt(cyc, 1, 1, 32'h100, 32'hB0000000);
    exp_own(cyc, 2'b10);
    tick();
    for (int b = 1; b < 4; b++) begin
      drive_dma(1, 1, 1, 32'h100 + 32'(4 * b), 32'hB0000000 + 32'(b));
      exp_gnt(cyc, 1, 1, 32'h100 + 32'(4 * b), 32'hB0000000 + 32'(b));
      exp_own(cyc, 2'b01);
      tick();
    end
    drive_dma(0, 0, 0, 32'h0, 32'h0);
    exp_own(cyc, 2'b01);
    tick();
    exp_gnt(cyc, 0, 0, 32'h10, 32'h0);
    exp_rd(cyc + 1, 0, 32'hDEADBEEF);
    exp_own(cyc, 2'b00);
    tick();
    drive_cpu(0, 0, 32'h0, 32'h0);

    // DMA reads back the burst without lock.
    for (int b = 0; b < 4; b++) begin
      drive_dma(1, 0, 0, 32'h100 + 32'(4 * b), 32'h0);
      exp_gnt(cyc, 1, 0, 32'h100 + 32'(4 * b), 32'h0);
      exp_rd(cyc + 1, 1, 32'hB0000000 + 32'(b));
      tick();
    end
    drive_dma(0, 0, 0, 32'h0, 32'h0);
    tick();

    // Reset arrives while a CPU read is in flight: its rvalid must never appear.
    drive_cpu(1, 0, 32'h10, 32'h0);
    exp_gnt(cyc, 0, 0, 32'h10, 32'h0);
    tick();
    rst = 1'b0;
    drive_cpu(0, 0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b1;
    exp_own(cyc, 2'b00);
    tick(); tick();
    drive_cpu(1, 0, 32'h20, 32'h0);
    exp_gnt(cyc, 0, 0, 32'h20, 32'h0);
    exp_rd(cyc + 1, 0, 32'h11112222);
    tick();
    drive_cpu(0, 0, 32'h0, 32'h0);
    repeat (3) tick();

    while (gq.size() > 0) begin
      g = gq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_grant: expected at cycle %0d addr %0h, never granted", g.cyc, g.addr);
    end
    while (rq.size() > 0) begin
      r = rq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_rvalid: expected at cycle %0d data %0h, never returned", r.cyc, r.data);
    end
    while (oq.size() > 0) begin
      o = oq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_owner_check: cycle %0d owner %0b never sampled", o.cyc, o.owner);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
